// File: rtl/tmc_uart_pkg.sv
// Shared framing constants and FSM encodings for the TMC byte UART and its controller.
package tmc_uart_pkg;
  localparam int DATA_BITS        = 8;
  localparam int QUARTERS_PER_BIT = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_CHECK_START,
    RX_READ,
    RX_CHECK_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SENDING,
    TX_STOP
  } tx_state_t;
endpackage

// File: rtl/tmc_byte_uart_sync2.sv
// Two-flop synchronizer; resets to 1 so a line held in reset reads as idle.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {q, meta} <= 2'b11;
    else     {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/tmc_byte_uart.sv
// Half-duplex 8N1 byte UART: independent quarter-bit timed transmitter and receiver.
module tmc_byte_uart
  import tmc_uart_pkg::*;
#(
  parameter int CLOCK_DIVIDE = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);
  localparam int             DW      = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [DW-1:0]  DIV_MAX = DW'(CLOCK_DIVIDE - 1);
  localparam logic [2:0]     QPB     = 3'(QUARTERS_PER_BIT);
  localparam logic [2:0]     HALF    = 3'(QUARTERS_PER_BIT / 2);

  logic rxs;
  sync2 u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs));

  // Prescalers: quarter tick every CLOCK_DIVIDE cycles, event when the quarter
  // down-counter expires; restart loads a fresh count so timing is edge-aligned.
  logic [DW-1:0] tx_div, rx_div;
  logic [2:0]    tx_qcnt, rx_qcnt, rx_load;
  logic          tx_restart, rx_restart;
  logic          tx_qtick, rx_qtick, tx_btick, rx_event;

  assign tx_qtick = (tx_div == DIV_MAX);
  assign rx_qtick = (rx_div == DIV_MAX);
  assign tx_btick = tx_qtick && (tx_qcnt == 3'd1);
  assign rx_event = rx_qtick && (rx_qcnt == 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_div  <= '0;
      tx_qcnt <= QPB;
    end else if (tx_restart) begin
      tx_div  <= '0;
      tx_qcnt <= QPB;
    end else begin
      tx_div <= tx_qtick ? '0 : tx_div + 1'b1;
      if (tx_qtick) tx_qcnt <= (tx_qcnt == 3'd1) ? QPB : tx_qcnt - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_div  <= '0;
      rx_qcnt <= QPB;
    end else if (rx_restart) begin
      rx_div  <= '0;
      rx_qcnt <= rx_load;
    end else begin
      rx_div <= rx_qtick ? '0 : rx_div + 1'b1;
      if (rx_qtick) rx_qcnt <= (rx_qcnt == 3'd1) ? QPB : rx_qcnt - 3'd1;
    end
  end

  // Transmitter
  tx_state_t  tx_state, tx_state_n;
  logic       tx_n, tx_busy_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [3:0] tx_bits, tx_bits_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state        <= TX_IDLE;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
      tx_shift        <= '0;
      tx_bits         <= '0;
    end else begin
      tx_state        <= tx_state_n;
      tx              <= tx_n;
      is_transmitting <= tx_busy_n;
      tx_shift        <= tx_shift_n;
      tx_bits         <= tx_bits_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_n       = tx;
    tx_busy_n  = is_transmitting;
    tx_shift_n = tx_shift;
    tx_bits_n  = tx_bits;
    tx_restart = 1'b0;
    case (tx_state)
      TX_IDLE: if (transmit) begin
        tx_state_n = TX_SENDING;
        tx_n       = 1'b0;
        tx_busy_n  = 1'b1;
        tx_shift_n = tx_byte;
        tx_bits_n  = '0;
        tx_restart = 1'b1;
      end
      TX_SENDING: if (tx_btick) begin
        if (tx_bits == 4'(DATA_BITS)) begin
          tx_n       = 1'b1;
          tx_state_n = TX_STOP;
        end else begin
          tx_n       = tx_shift[0];
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bits_n  = tx_bits + 4'd1;
        end
      end
      TX_STOP: if (tx_btick) begin
        tx_state_n = TX_IDLE;
        tx_busy_n  = 1'b0;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Receiver
  rx_state_t  rx_state, rx_state_n;
  logic [7:0] rx_data, rx_data_n, rx_byte_n;
  logic [3:0] rx_bits, rx_bits_n;
  logic       received_n, recv_error_n, rx_busy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      rx_data      <= '0;
      rx_bits      <= '0;
      rx_byte      <= '0;
      received     <= 1'b0;
      recv_error   <= 1'b0;
      is_receiving <= 1'b0;
    end else begin
      rx_state     <= rx_state_n;
      rx_data      <= rx_data_n;
      rx_bits      <= rx_bits_n;
      rx_byte      <= rx_byte_n;
      received     <= received_n;
      recv_error   <= recv_error_n;
      is_receiving <= rx_busy_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_data_n    = rx_data;
    rx_bits_n    = rx_bits;
    rx_byte_n    = rx_byte;
    received_n   = 1'b0;
    recv_error_n = 1'b0;
    rx_busy_n    = (received || recv_error) ? 1'b0 : is_receiving;
    rx_restart   = 1'b0;
    rx_load      = QPB;
    case (rx_state)
      RX_IDLE: if (!rxs) begin
        rx_state_n = RX_CHECK_START;
        rx_restart = 1'b1;
        rx_load    = HALF;
        rx_busy_n  = 1'b1;
      end
      RX_CHECK_START: if (rx_event) begin
        if (rxs) begin
          rx_state_n = RX_IDLE;
          rx_busy_n  = 1'b0;
        end else begin
          rx_state_n = RX_READ;
          rx_bits_n  = '0;
        end
      end
      RX_READ: if (rx_event) begin
        rx_data_n = {rxs, rx_data[7:1]};
        rx_bits_n = rx_bits + 4'd1;
        if (rx_bits == 4'(DATA_BITS - 1)) rx_state_n = RX_CHECK_STOP;
      end
      RX_CHECK_STOP: if (rx_event) begin
        if (rxs) begin
          rx_byte_n  = rx_data;
          received_n = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          recv_error_n = 1'b1;
          rx_state_n   = RX_WAIT_IDLE;
        end
      end
      // Any low sample restarts the full-bit high window.
      RX_WAIT_IDLE: begin
        if (!rxs) rx_restart = 1'b1;
        else if (rx_event) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_tmc_byte_uart.sv
// Directed bench for tmc_byte_uart: TX bit timing, RX framing, glitch, framing error, mid-frame reset.
module tb_tmc_byte_uart;
  localparam int CD = 48;
  localparam int T  = 4 * CD;

  logic       clk = 1'b0;
  logic       rst, rx, tx, transmit, received, is_receiving, is_transmitting, recv_error;
  logic [7:0] tx_byte, rx_byte;
  int         n_chk = 0, n_fail = 0;
  int         rcv_cnt = 0, err_cnt = 0;
  int         rcv_base, err_base;

  tmc_byte_uart #(.CLOCK_DIVIDE(CD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .transmit(transmit), .tx_byte(tx_byte),
    .received(received), .rx_byte(rx_byte), .is_receiving(is_receiving),
    .is_transmitting(is_transmitting), .recv_error(recv_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (received)   rcv_cnt++;
    if (recv_error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_frame(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    transmit = 1'b1;
    tx_byte  = b;
    wait_cyc(1);
    transmit = 1'b0;
    chk("tx_busy_rise", is_transmitting, 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_bit%0d_first", i), tx, fr[i]);
      wait_cyc(T - 1);
      chk($sformatf("tx_bit%0d_last", i), tx, fr[i]);
      if (i == 9) chk("tx_busy_last", is_transmitting, 1);
      wait_cyc(1);
    end
    chk("tx_busy_fall", is_transmitting, 0);
    chk("tx_idle_high", tx, 1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input int bt, input logic stop_val);
    rx = 1'b0;
    wait_cyc(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(bt);
    end
    rx = stop_val;
    wait_cyc(bt);
    rx = 1'b1;
  endtask

  task automatic rx_expect(input string tag, input int drcv, input int derr, input logic [7:0] b);
    chk({tag, "_rcv"}, rcv_cnt - rcv_base, drcv);
    chk({tag, "_err"}, err_cnt - err_base, derr);
    chk({tag, "_byte"}, rx_byte, b);
    chk({tag, "_busy"}, is_receiving, 0);
    rcv_base = rcv_cnt;
    err_base = err_cnt;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; transmit = 1'b0; tx_byte = '0;
    wait_cyc(3);
    chk("rst_tx", tx, 1);
    chk("rst_received", received, 0);
    chk("rst_recv_error", recv_error, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_is_receiving", is_receiving, 0);
    chk("rst_is_transmitting", is_transmitting, 0);
    rst = 1'b0;
    wait_cyc(4);
    rcv_base = rcv_cnt;
    err_base = err_cnt;

    tx_frame(8'h05);

    rx_frame(8'hA5, T, 1'b1);
    wait_cyc(T);
    rx_expect("rx_a5", 1, 0, 8'hA5);

    rx_frame(8'h3C, T - 6, 1'b1);
    wait_cyc(T);
    rx_expect("rx_3c_fast", 1, 0, 8'h3C);
    rx_frame(8'h3C, T + 6, 1'b1);
    wait_cyc(T);
    rx_expect("rx_3c_slow", 1, 0, 8'h3C);

    rx = 1'b0;
    wait_cyc(20);
    chk("glitch_busy", is_receiving, 1);
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(100);
    rx_expect("glitch", 0, 0, 8'h3C);

    rx_frame(8'h81, T, 1'b0);
    rx = 1'b0;
    wait_cyc(3 * T);
    rx = 1'b1;
    wait_cyc(2 * T);
    rx_expect("frame_err", 0, 1, 8'h3C);
    rx_frame(8'hFF, T, 1'b1);
    wait_cyc(T);
    rx_expect("after_err", 1, 0, 8'hFF);

    transmit = 1'b1;
    tx_byte  = 8'h00;
    wait_cyc(1);
    transmit = 1'b0;
    wait_cyc(4 * T + T / 2);
    chk("txrst_pre_low", tx, 0);
    rst = 1'b1;
    #1;
    chk("txrst_tx_async", tx, 1);
    chk("txrst_busy", is_transmitting, 0);
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(5);
    tx_frame(8'h11);

    fork
      rx_frame(8'h5A, T, 1'b1);
      begin
        wait_cyc(4 * T + T / 2);
        chk("rxrst_pre_busy", is_receiving, 1);
        rst = 1'b1;
        #1;
        chk("rxrst_busy", is_receiving, 0);
      end
    join
    wait_cyc(T);
    rst = 1'b0;
    wait_cyc(5);
    rx_expect("rxrst", 0, 0, 8'h00);
    rx_frame(8'h11, T, 1'b1);
    wait_cyc(T);
    rx_expect("rx_11", 1, 0, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
